health_controller: RTL and testbench

Arbitrates damage and heal events against the player's health register in the space-shooter game loop. Collision sources (enemy bullets, enemy bodies, hazards) raise hit requests; the block grants at most one per frame tick round-robin, applies per-source damage, enforces a post-hit invulnerability window, and drives game-over. It sits between the collision detectors and the HEX health display / main control FSM.

---
 rtl/space_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/health_controller.sv | 154 +++++++++++++++
 tb/tb_health_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/space_pkg.sv
// Shared constants and state encoding for the space-shooter game-loop blocks.
package space_pkg;

    localparam int HEALTH_W   = 4;
    localparam int MAX_HEALTH = 10;
    localparam int DMG_W      = 2;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o
);
    import space_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o   = '0;
        grant_idx = ptr_q;
        idx       = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                grant_o[idx]   = 1'b1;
                grant_idx      = idx;
            end
        end
        ptr_d = (en_i && found) ? grant_idx : ptr_q;
    end

    // Pointer holds the last granted index; resetting to the top slot makes req 0 win first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/health_controller.sv
// Player health controller: per-frame round-robin hit arbitration, healing,
// post-hit invulnerability window and game-over.
module health_controller #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_HEALTH    = space_pkg::MAX_HEALTH,
    parameter int HEALTH_W      = space_pkg::HEALTH_W,
    parameter int INVULN_FRAMES = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_tick,
    input  logic [NUM_REQ-1:0]                hit_req,
    input  logic [space_pkg::DMG_W*NUM_REQ-1:0] hit_dmg,
    input  logic                              heal_req,
    input  logic                              restart,
    output logic [NUM_REQ-1:0]                hit_ack,
    output logic                              heal_ack,
    output logic [HEALTH_W-1:0]               health,
    output logic                              invuln,
    output logic                              game_over
);
    import space_pkg::*;

    localparam int INV_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;

    state_e               state_q, state_d;
    logic [HEALTH_W-1:0]  health_q, health_d;
    logic [INV_W-1:0]     inv_cnt_q, inv_cnt_d;
    logic [NUM_REQ-1:0]   hit_ack_q, hit_ack_d;
    logic                 heal_ack_q, heal_ack_d;

    logic                 tick;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   grant;
    logic [DMG_W-1:0]     dmg_sel;
    logic [DMG_W-1:0]     dmg_eff;
    logic [HEALTH_W-1:0]  hit_health;
    logic [HEALTH_W-1:0]  heal_health;

    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h,
                                                    input logic [DMG_W-1:0]    d);
        logic [HEALTH_W-1:0] dx;
        dx = HEALTH_W'(d);
        return (h > dx) ? (h - dx) : '0;
    endfunction

    function automatic logic [HEALTH_W-1:0] sat_inc(input logic [HEALTH_W-1:0] h);
        return (h >= HEALTH_W'(MAX_HEALTH)) ? HEALTH_W'(MAX_HEALTH) : (h + HEALTH_W'(1));
    endfunction

    // A tick landing while the previous acks are still up violates the requester
    // contract and is dropped rather than double-serviced.
    assign tick   = frame_tick && !restart && !(|hit_ack_q) && !heal_ack_q;
    assign arb_en = tick && (state_q == ALIVE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (arb_en),
        .req_i   (hit_req),
        .grant_o (grant)
    );

    always_comb begin
        dmg_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                dmg_sel = dmg_sel | hit_dmg[DMG_W*i +: DMG_W];
            end
        end
        dmg_eff = (dmg_sel == '0) ? DMG_W'(1) : dmg_sel;
    end

    assign hit_health  = sat_sub(health_q, dmg_eff);
    assign heal_health = sat_inc(health_q);

    always_comb begin
        state_d    = state_q;
        health_d   = health_q;
        inv_cnt_d  = inv_cnt_q;
        hit_ack_d  = '0;
        heal_ack_d = 1'b0;
        if (restart) begin
            state_d   = ALIVE;
            health_d  = HEALTH_W'(MAX_HEALTH);
            inv_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                ALIVE: begin
                    if (|hit_req) begin
                        health_d  = hit_health;
                        hit_ack_d = grant;
                        if (hit_health == '0) begin
                            state_d   = DEAD;
                            inv_cnt_d = '0;
                        end else begin
                            state_d   = INVULN;
                            inv_cnt_d = INV_W'(INVULN_FRAMES);
                        end
                    end else if (heal_req) begin
                        health_d   = heal_health;
                        heal_ack_d = 1'b1;
                    end
                end
                INVULN: begin
                    hit_ack_d = hit_req;
                    if (heal_req) begin
                        health_d   = heal_health;
                        heal_ack_d = 1'b1;
                    end
                    if (inv_cnt_q == INV_W'(1)) begin
                        state_d   = ALIVE;
                        inv_cnt_d = '0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - INV_W'(1);
                    end
                end
                DEAD: begin
                    hit_ack_d  = hit_req;
                    heal_ack_d = heal_req;
                    health_d   = '0;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ALIVE;
            health_q   <= HEALTH_W'(MAX_HEALTH);
            inv_cnt_q  <= '0;
            hit_ack_q  <= '0;
            heal_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            health_q   <= health_d;
            inv_cnt_q  <= inv_cnt_d;
            hit_ack_q  <= hit_ack_d;
            heal_ack_q <= heal_ack_d;
        end
    end

    assign hit_ack   = hit_ack_q;
    assign heal_ack  = heal_ack_q;
    assign health    = health_q;
    assign invuln    = (state_q == INVULN);
    assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_health_controller.sv
// Scoreboard bench for health_controller: reference model pushes expectations,
// a monitor pops and compares after every tick/restart edge.
module tb_health_controller;

    localparam int NREQ = 4;
    localparam int MAXH = 10;
    localparam int INVF = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [3:0] hit_req;
    logic [7:0] hit_dmg;
    logic       heal_req;
    logic       restart;
    logic [3:0] hit_ack;
    logic       heal_ack;
    logic [3:0] health;
    logic       invuln;
    logic       game_over;

    health_controller #(
        .NUM_REQ       (NREQ),
        .MAX_HEALTH    (MAXH),
        .HEALTH_W      (4),
        .INVULN_FRAMES (INVF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .hit_req    (hit_req),
        .hit_dmg    (hit_dmg),
        .heal_req   (heal_req),
        .restart    (restart),
        .hit_ack    (hit_ack),
        .heal_ack   (heal_ack),
        .health     (health),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       hp;
        logic     inv;
        logic     go;
        logic [3:0] hack;
        logic     healack;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: mode 0=alive, 1=invulnerable, 2=dead
    int m_hp   = MAXH;
    int m_mode = 0;
    int m_inv  = 0;
    int m_last = NREQ - 1;

    logic [3:0] req_v  = '0;
    logic       heal_v = 1'b0;
    logic       sampled = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [3:0] rq, input logic [7:0] dm, input logic hl,
                         input logic rs, output exp_t e);
        int g;
        int k;
        int d;
        e.hack    = '0;
        e.healack = 1'b0;
        if (rs) begin
            m_hp   = MAXH;
            m_mode = 0;
            m_inv  = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (rq != 0) begin
                        g = -1;
                        for (int j = 1; j <= NREQ; j++) begin
                            k = (m_last + j) % NREQ;
                            if (g < 0 && rq[k]) g = k;
                        end
                        d = (int'(dm) >> (2 * g)) & 3;
                        if (d == 0) d = 1;
                        m_hp   = (m_hp > d) ? m_hp - d : 0;
                        e.hack = 4'(1 << g);
                        m_last = g;
                        if (m_hp == 0) m_mode = 2;
                        else begin
                            m_mode = 1;
                            m_inv  = INVF;
                        end
                    end else if (hl) begin
                        if (m_hp < MAXH) m_hp++;
                        e.healack = 1'b1;
                    end
                end
                1: begin
                    e.hack = rq;
                    if (hl) begin
                        if (m_hp < MAXH) m_hp++;
                        e.healack = 1'b1;
                    end
                    if (m_inv == 1) m_mode = 0;
                    else m_inv--;
                end
                default: begin
                    e.hack    = rq;
                    e.healack = hl;
                end
            endcase
        end
        e.hp  = m_hp;
        e.inv = (m_mode == 1);
        e.go  = (m_mode == 2);
    endtask

    task automatic do_tick(input logic [3:0] add, input logic [7:0] dmg, input logic heal,
                           input logic rs, input logic tk);
        exp_t e;
        @(negedge clk);
        req_v  = req_v | add;
        heal_v = heal_v | heal;
        hit_req    = req_v;
        hit_dmg    = dmg;
        heal_req   = heal_v;
        restart    = rs;
        frame_tick = tk;
        model(req_v, dmg, heal_v, rs, e);
        expq.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        restart    = 1'b0;
        req_v      = req_v & ~e.hack;
        if (e.healack) heal_v = 1'b0;
        hit_req    = req_v;
        heal_req   = heal_v;
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n, input logic [3:0] add);
        for (int i = 0; i < n; i++) begin
            do_tick(add, 8'($urandom), 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic hit(input int src, input int dmg);
        do_tick(4'(1 << src), 8'(dmg << (2 * src)), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_health", health, MAXH);
        chk("rst_invuln", invuln, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_hit_ack", hit_ack, 0);
        chk("rst_heal_ack", heal_ack, 0);
        req_v      = '0;
        heal_v     = 1'b0;
        hit_req    = '0;
        heal_req   = 1'b0;
        frame_tick = 1'b0;
        restart    = 1'b0;
        m_hp   = MAXH;
        m_mode = 0;
        m_inv  = 0;
        m_last = NREQ - 1;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    always @(posedge clk) sampled <= (frame_tick | restart) & ~reset;

    // Monitor: consumes one expectation per sampled tick/restart, otherwise checks hold behaviour.
    initial begin
        exp_t e;
        exp_t hold;
        hold.hp = MAXH; hold.inv = 1'b0; hold.go = 1'b0; hold.hack = '0; hold.healack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold.hp = MAXH; hold.inv = 1'b0; hold.go = 1'b0;
            end else if (sampled) begin
                chk("queue_nonempty", (expq.size() > 0) ? 1 : 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("health", health, e.hp);
                    chk("invuln", invuln, e.inv);
                    chk("game_over", game_over, e.go);
                    chk("hit_ack", hit_ack, e.hack);
                    chk("heal_ack", heal_ack, e.healack);
                    hold = e;
                end
            end else begin
                chk("idle_hit_ack", hit_ack, 0);
                chk("idle_heal_ack", heal_ack, 0);
                chk("idle_health", health, hold.hp);
                chk("idle_invuln", invuln, hold.inv);
                chk("idle_game_over", game_over, hold.go);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        hit_req    = '0;
        hit_dmg    = '0;
        heal_req   = 1'b0;
        restart    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_health", health, MAXH);
        chk("init_invuln", invuln, 0);
        chk("init_game_over", game_over, 0);
        chk("init_hit_ack", hit_ack, 0);
        @(negedge clk);
        #1 reset = 1'b0;

        // First hit, invulnerable window swallowing hits, then reset mid-window
        hit(0, 2);
        idle_ticks(INVF, 4'b0110);
        hit(3, 1);
        idle_ticks(1, 4'b0001);
        do_reset();

        // Round-robin order from reset with all sources held
        for (int r = 0; r < 5; r++) begin
            do_tick(4'hF, 8'h55, 1'b0, 1'b0, 1'b1);
            idle_ticks(INVF, 4'h0);
        end

        // Saturating kill, dead-state acks, restart overriding a tick
        do_tick(4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
        hit(1, 2); idle_ticks(INVF, 4'h0);
        hit(1, 3); idle_ticks(INVF, 4'h0);
        hit(1, 3); idle_ticks(INVF, 4'h0);
        hit(1, 3);
        do_tick(4'hF, 8'hFF, 1'b1, 1'b0, 1'b1);
        do_tick(4'h5, 8'h00, 1'b0, 1'b0, 1'b1);
        do_tick(4'b0100, 8'h30, 1'b0, 1'b1, 1'b1);
        do_tick(4'h0, 8'h30, 1'b0, 1'b0, 1'b1);
        idle_ticks(INVF, 4'h0);

        // Healing: cap at max, still acked, and hit wins over heal
        do_tick(4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
        hit(2, 1); idle_ticks(INVF, 4'h0);
        do_tick(4'h0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_tick(4'h0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_tick(4'b0001, 8'h01, 1'b1, 1'b0, 1'b1);
        idle_ticks(INVF, 4'h0);

        // Randomized traffic
        for (int r = 0; r < 120; r++) begin
            logic       rs;
            logic       tk;
            rs = ($urandom_range(0, 15) == 0);
            tk = rs ? 1'($urandom_range(0, 1)) : 1'b1;
            do_tick(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 8'($urandom),
                    ($urandom_range(0, 3) == 0), rs, tk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
